// File: rtl/pong_pkg.sv
// Shared playfield geometry and state/direction types for the pong ball engine.
package pong_pkg;

  localparam int X_WIDTH     = 10;
  localparam int Y_WIDTH     = 10;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_H    = 64;
  localparam int PADDLE_L_X  = 16;
  localparam int PADDLE_R_X  = 616;
  localparam int SPEED       = 2;
  localparam int SERVE_DELAY = 60;

  typedef enum logic [1:0] {SERVE, PLAY, GOAL} ball_state_t;
  typedef enum logic {DIR_NEG, DIR_POS} dir_t;

endpackage

// File: rtl/serve_delay_counter.sv
// Counts frame ticks while the ball rests at centre; done flags the tick that
// completes the serve delay.
module serve_delay_counter #(
  parameter int SERVE_DELAY = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic clear,
  output logic done
);

  localparam int CW = $clog2(SERVE_DELAY + 1);

  logic [CW-1:0] count_q;

  assign done = enable && tick && (count_q == CW'(SERVE_DELAY - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && tick && (count_q < CW'(SERVE_DELAY))) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Pong ball position engine: serve delay, wall/paddle bounces and goal detection,
// all advanced once per frame_tick.
module ball_motion #(
  parameter int X_WIDTH     = pong_pkg::X_WIDTH,
  parameter int Y_WIDTH     = pong_pkg::Y_WIDTH,
  parameter int SCREEN_W    = pong_pkg::SCREEN_W,
  parameter int SCREEN_H    = pong_pkg::SCREEN_H,
  parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int PADDLE_W    = pong_pkg::PADDLE_W,
  parameter int PADDLE_H    = pong_pkg::PADDLE_H,
  parameter int PADDLE_L_X  = pong_pkg::PADDLE_L_X,
  parameter int PADDLE_R_X  = pong_pkg::PADDLE_R_X,
  parameter int SPEED       = pong_pkg::SPEED,
  parameter int SERVE_DELAY = pong_pkg::SERVE_DELAY
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [Y_WIDTH-1:0] paddle_l_y,
  input  logic [Y_WIDTH-1:0] paddle_r_y,
  output logic [X_WIDTH-1:0] ball_x_coords,
  output logic [Y_WIDTH-1:0] ball_y_coords,
  output logic               ball_moving,
  output logic               goal_left,
  output logic               goal_right
);

  import pong_pkg::*;

  localparam int XW = X_WIDTH + 1;
  localparam int YW = Y_WIDTH + 1;

  localparam logic [X_WIDTH-1:0] CX = X_WIDTH'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [Y_WIDTH-1:0] CY = Y_WIDTH'((SCREEN_H - BALL_SIZE) / 2);

  localparam logic [XW-1:0] LF_X  = XW'(PADDLE_L_X + PADDLE_W);
  localparam logic [XW-1:0] PRX_X = XW'(PADDLE_R_X);
  localparam logic [XW-1:0] SPD_X = XW'(SPEED);
  localparam logic [XW-1:0] BS_X  = XW'(BALL_SIZE);
  localparam logic [XW-1:0] SW_X  = XW'(SCREEN_W);
  localparam logic [YW-1:0] SPD_Y = YW'(SPEED);
  localparam logic [YW-1:0] BS_Y  = YW'(BALL_SIZE);
  localparam logic [YW-1:0] SH_Y  = YW'(SCREEN_H);
  localparam logic [YW-1:0] PH_Y  = YW'(PADDLE_H);

  ball_state_t        state_q, state_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  dir_t               dx_q, dx_d, dy_q, dy_d;
  logic               goal_l_q, goal_l_d, goal_r_q, goal_r_d;
  logic               cnt_clear, serve_done, in_serve;

  // Widened views so the bounds arithmetic cannot wrap
  logic [XW-1:0] xw;
  logic [YW-1:0] yw, pl_w, pr_w;
  logic          overlap_l, overlap_r;

  assign xw        = {1'b0, x_q};
  assign yw        = {1'b0, y_q};
  assign pl_w      = {1'b0, paddle_l_y};
  assign pr_w      = {1'b0, paddle_r_y};
  assign overlap_l = (yw + BS_Y > pl_w) && (yw < pl_w + PH_Y);
  assign overlap_r = (yw + BS_Y > pr_w) && (yw < pr_w + PH_Y);
  assign in_serve  = (state_q == SERVE);

  serve_delay_counter #(
    .SERVE_DELAY(SERVE_DELAY)
  ) u_serve_delay (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick),
    .enable(in_serve),
    .clear (cnt_clear),
    .done  (serve_done)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    goal_l_d  = 1'b0;
    goal_r_d  = 1'b0;
    cnt_clear = 1'b0;
    if (frame_tick) begin
      case (state_q)
        SERVE: if (serve_done) state_d = PLAY;
        PLAY: begin
          if (dy_q == DIR_NEG) begin
            if (yw < SPD_Y) begin
              y_d  = '0;
              dy_d = DIR_POS;
            end else begin
              y_d = Y_WIDTH'(yw - SPD_Y);
            end
          end else if (yw + BS_Y + SPD_Y > SH_Y) begin
            y_d  = Y_WIDTH'(SH_Y - BS_Y);
            dy_d = DIR_NEG;
          end else begin
            y_d = Y_WIDTH'(yw + SPD_Y);
          end
          // Paddle faces only catch a ball arriving from the playfield side
          if (dx_q == DIR_NEG) begin
            if ((xw >= LF_X) && (xw <= LF_X + SPD_X) && overlap_l) begin
              x_d  = X_WIDTH'(LF_X);
              dx_d = DIR_POS;
            end else if (xw < SPD_X) begin
              x_d      = '0;
              goal_l_d = 1'b1;
              state_d  = GOAL;
            end else begin
              x_d = X_WIDTH'(xw - SPD_X);
            end
          end else begin
            if ((xw + BS_X <= PRX_X) && (xw + BS_X + SPD_X >= PRX_X) && overlap_r) begin
              x_d  = X_WIDTH'(PRX_X - BS_X);
              dx_d = DIR_NEG;
            end else if (xw + BS_X + SPD_X > SW_X) begin
              x_d      = X_WIDTH'(SW_X - BS_X);
              goal_r_d = 1'b1;
              state_d  = GOAL;
            end else begin
              x_d = X_WIDTH'(xw + SPD_X);
            end
          end
        end
        GOAL: begin
          // The ball exited in its travel direction, so re-serve the other way
          x_d       = CX;
          y_d       = CY;
          dx_d      = (dx_q == DIR_NEG) ? DIR_POS : DIR_NEG;
          cnt_clear = 1'b1;
          state_d   = SERVE;
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SERVE;
      x_q      <= CX;
      y_q      <= CY;
      dx_q     <= DIR_POS;
      dy_q     <= DIR_POS;
      goal_l_q <= 1'b0;
      goal_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      goal_l_q <= goal_l_d;
      goal_r_q <= goal_r_d;
    end
  end

  assign ball_x_coords = x_q;
  assign ball_y_coords = y_q;
  assign ball_moving   = (state_q == PLAY);
  assign goal_left     = goal_l_q;
  assign goal_right    = goal_r_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: vector table for serve timing, directed goal/bounce/reset
// sequences, then randomized play against a behavioural model.
module tb_ball_motion;

  localparam int CX = 316;
  localparam int CY = 236;
  localparam int SERVE_DELAY = 60;
  localparam int NO_PADDLE = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] paddle_l_y = 10'd1000;
  logic [9:0] paddle_r_y = 10'd1000;
  logic [9:0] ball_x_coords, ball_y_coords;
  logic       ball_moving, goal_left, goal_right;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .paddle_l_y   (paddle_l_y),
    .paddle_r_y   (paddle_r_y),
    .ball_x_coords(ball_x_coords),
    .ball_y_coords(ball_y_coords),
    .ball_moving  (ball_moving),
    .goal_left    (goal_left),
    .goal_right   (goal_right)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: phase 0 = resting at centre, 1 = in play, 2 = just scored
  int mx, my, mphase, mframes;
  bit moving_right, moving_down, mgl, mgr, last_scorer_left;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit tk, input int pl, input int pr);
    int nx, ny;
    bit hit_l, hit_r;
    if (rst) begin
      mx = CX; my = CY; moving_right = 1; moving_down = 1;
      mphase = 0; mframes = 0; mgl = 0; mgr = 0;
      return;
    end
    mgl = 0;
    mgr = 0;
    if (!tk) return;
    if (mphase == 0) begin
      mframes++;
      if (mframes == SERVE_DELAY) mphase = 1;
    end else if (mphase == 2) begin
      mx = CX; my = CY; mframes = 0; mphase = 0;
      moving_right = last_scorer_left;
    end else begin
      hit_l = (my + 8 > pl) && (my < pl + 64);
      hit_r = (my + 8 > pr) && (my < pr + 64);
      if (moving_down) begin
        if (my + 8 + 2 > 480) begin ny = 480 - 8; moving_down = 0; end
        else ny = my + 2;
      end else begin
        if (my < 2) begin ny = 0; moving_down = 1; end
        else ny = my - 2;
      end
      if (!moving_right) begin
        if (mx >= 24 && mx - 2 <= 24 && hit_l) begin nx = 24; moving_right = 1; end
        else if (mx < 2) begin nx = 0; mgl = 1; mphase = 2; last_scorer_left = 1; end
        else nx = mx - 2;
      end else begin
        if (mx + 8 <= 616 && mx + 8 + 2 >= 616 && hit_r) begin nx = 608; moving_right = 0; end
        else if (mx + 8 + 2 > 640) begin nx = 632; mgr = 1; mphase = 2; last_scorer_left = 0; end
        else nx = mx + 2;
      end
      mx = nx;
      my = ny;
    end
  endtask

  task automatic step(input bit rst, input bit tk);
    reset = rst;
    frame_tick = tk;
    model_step(rst, tk, int'(paddle_l_y), int'(paddle_r_y));
    @(posedge clk);
    #1;
    reset = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic compare_model();
    check("x_vs_model", int'(ball_x_coords), mx);
    check("y_vs_model", int'(ball_y_coords), my);
    check("moving_vs_model", int'(ball_moving), int'(mphase == 1));
    check("goal_left_vs_model", int'(goal_left), int'(mgl));
    check("goal_right_vs_model", int'(goal_right), int'(mgr));
  endtask

  function automatic logic [9:0] track(input int y);
    return (y >= 20) ? 10'(y - 20) : 10'd0;
  endfunction

  typedef struct {
    int ticks;
    int ex;
    int ey;
    int emov;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit found;

    vecs[0] = '{0,  316, 236, 0};
    vecs[1] = '{59, 316, 236, 0};
    vecs[2] = '{1,  316, 236, 1};
    vecs[3] = '{1,  318, 238, 1};
    vecs[4] = '{10, 338, 258, 1};

    step(1, 0);
    step(1, 1);
    for (int i = 0; i < 5; i++) begin
      for (int t = 0; t < vecs[i].ticks; t++) step(0, 1);
      check($sformatf("vec%0d_x", i), int'(ball_x_coords), vecs[i].ex);
      check($sformatf("vec%0d_y", i), int'(ball_y_coords), vecs[i].ey);
      check($sformatf("vec%0d_moving", i), int'(ball_moving), vecs[i].emov);
      check($sformatf("vec%0d_goals", i), int'({goal_left, goal_right}), 0);
    end

    // Right goal with no paddles in the way
    found = 0;
    for (int t = 0; t < 400 && !found; t++) begin
      step(0, 1);
      compare_model();
      if (goal_right) found = 1;
    end
    check("goal_right_seen", int'(found), 1);
    check("goal_right_x", int'(ball_x_coords), 632);
    check("goal_right_no_left", int'(goal_left), 0);
    check("goal_state_not_moving", int'(ball_moving), 0);
    step(0, 0);
    check("goal_right_pulse_ends", int'(goal_right), 0);
    check("goal_hold_x", int'(ball_x_coords), 632);
    step(0, 1);
    check("reserve_x", int'(ball_x_coords), CX);
    check("reserve_y", int'(ball_y_coords), CY);
    check("reserve_moving", int'(ball_moving), 0);
    for (int t = 0; t < 60; t++) step(0, 1);
    check("serve_left_start", int'(ball_x_coords), CX);
    step(0, 1);
    check("serve_left_dir", int'(ball_x_coords), 314);

    // Left paddle tracks the ball and returns it
    found = 0;
    for (int t = 0; t < 400 && !found; t++) begin
      paddle_l_y = track(my);
      step(0, 1);
      compare_model();
      if (ball_x_coords == 10'd24) found = 1;
    end
    check("left_face_reached", int'(found), 1);
    check("left_bounce_no_goal", int'(goal_left), 0);
    paddle_l_y = track(my);
    step(0, 1);
    check("left_bounce_x", int'(ball_x_coords), 26);
    check("left_bounce_no_goal2", int'(goal_left), 0);

    // Right paddle returns it, left paddle absent: left goal
    paddle_l_y = 10'(NO_PADDLE);
    found = 0;
    for (int t = 0; t < 1000 && !found; t++) begin
      paddle_r_y = track(my);
      step(0, 1);
      compare_model();
      if (goal_left) found = 1;
    end
    check("goal_left_seen", int'(found), 1);
    check("goal_left_x", int'(ball_x_coords), 0);
    check("goal_left_no_right", int'(goal_right), 0);
    step(0, 0);
    check("goal_left_pulse_ends", int'(goal_left), 0);
    step(0, 1);
    check("reserve2_x", int'(ball_x_coords), CX);
    check("reserve2_y", int'(ball_y_coords), CY);
    for (int t = 0; t < 61; t++) step(0, 1);
    check("serve_right_dir", int'(ball_x_coords), 318);
    check("serve_right_moving", int'(ball_moving), 1);

    // Reset in mid-play together with a frame tick
    step(1, 1);
    check("midreset_x", int'(ball_x_coords), CX);
    check("midreset_y", int'(ball_y_coords), CY);
    check("midreset_moving", int'(ball_moving), 0);
    check("midreset_goals", int'({goal_left, goal_right}), 0);
    for (int t = 0; t < 59; t++) step(0, 1);
    check("midreset_still_serving", int'(ball_moving), 0);
    step(0, 1);
    check("midreset_serve_done", int'(ball_moving), 1);
    check("midreset_no_move_on_start", int'(ball_x_coords), CX);

    // Randomized play against the model
    for (int c = 0; c < 5000; c++) begin
      paddle_l_y = ($urandom_range(0, 3) != 0) ? track(my + int'($urandom_range(0, 30)))
                                               : 10'($urandom_range(0, 1023));
      paddle_r_y = ($urandom_range(0, 3) != 0) ? track(my + int'($urandom_range(0, 30)))
                                               : 10'($urandom_range(0, 1023));
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 2) != 0);
      compare_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
